// File: rtl/bcd_counter_ndigit.sv
// bcd_counter_ndigit: parametrised N-digit synchronous BCD up/down counter
// with parallel load (non-BCD nibbles clamped to 9), wrap or saturate at
// the terminal values, and a registered carry/borrow pulse for cascading.
//
// Control semantics: there is no handshake. Every rising clk edge samples
// grst, load, enable and up with fixed priority reset > load > enable, and
// all outputs are registered (one clock of latency).
module bcd_counter_ndigit #(
  parameter int DIGITS = 4,
  parameter int SATURATE = 0,
  parameter logic [4*DIGITS-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                grst,
  input  logic                enable,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                cout,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;
  localparam bit SAT = (SATURATE != 0);

  // Parameter legality is enforced at elaboration time.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_counter_ndigit: DIGITS must be in 1..8");
  end
  for (genvar g = 0; g < DIGITS; g++) begin : g_rv_chk
    if (RESET_VAL[4*g+3:4*g] > 4'd9) begin : g_bad_rv
      $error("bcd_counter_ndigit: RESET_VAL contains a non-BCD nibble");
    end
  end

  logic [W-1:0]    count_q;
  logic [W-1:0]    step_val;
  logic [W-1:0]    load_clamped;
  logic            load_bad;
  logic            term;
  // low9[k]: every digit below k is 9; low0[k]: every digit below k is 0.
  // Index DIGITS therefore flags the TOP and BOT terminal values.
  logic [DIGITS:0] low9;
  logic [DIGITS:0] low0;

  assign low9[0] = 1'b1;
  assign low0[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_chain
    assign low9[g+1] = low9[g] && (count_q[4*g +: 4] == 4'd9);
    assign low0[g+1] = low0[g] && (count_q[4*g +: 4] == 4'd0);
  end

  assign term = up ? low9[DIGITS] : low0[DIGITS];

  // Per-digit step: each digit moves when all lower digits sit at the
  // rollover value, so there is no inter-digit ripple latency. At a terminal
  // value every digit rolls over, which gives BOT/TOP wrap for free.
  always_comb begin
    step_val = count_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (up) begin
        if (low9[k]) begin
          step_val[4*k +: 4] = (count_q[4*k +: 4] == 4'd9) ? 4'd0
                                                           : count_q[4*k +: 4] + 4'd1;
        end
      end else begin
        if (low0[k]) begin
          step_val[4*k +: 4] = (count_q[4*k +: 4] == 4'd0) ? 4'd9
                                                           : count_q[4*k +: 4] - 4'd1;
        end
      end
    end
  end

  // Load clamping: any nibble above 9 becomes 9 and flags an error.
  always_comb begin
    load_clamped = load_val;
    load_bad     = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] > 4'd9) begin
        load_clamped[4*k +: 4] = 4'd9;
        load_bad               = 1'b1;
      end
    end
  end

  // Count and pulse registers with reset > load > enable priority.
  always_ff @(posedge clk) begin
    if (!grst) begin
      count_q  <= RESET_VAL;
      cout     <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      count_q  <= load_clamped;
      cout     <= 1'b0;
      load_err <= load_bad;
    end else if (enable) begin
      if (!(SAT && term)) begin
        count_q <= step_val;
      end
      cout     <= term;
      load_err <= 1'b0;
    end else begin
      cout     <= 1'b0;
      load_err <= 1'b0;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// tb_bcd_counter_ndigit: directed vectors with hand-computed expectations
// against four configurations: 4-digit wrap, 4-digit saturate, 1-digit and
// 8-digit wrap.
module tb_bcd_counter_ndigit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // 4-digit wrap instance
  logic        a_grst, a_en, a_up, a_load, a_cout, a_err;
  logic [15:0] a_lv, a_cnt;
  // 4-digit saturate instance
  logic        s_grst, s_en, s_up, s_load, s_cout, s_err;
  logic [15:0] s_lv, s_cnt;
  // 1-digit instance
  logic        b_grst, b_en, b_up, b_load, b_cout, b_err;
  logic [3:0]  b_lv, b_cnt;
  // 8-digit instance
  logic        c_grst, c_en, c_up, c_load, c_cout, c_err;
  logic [31:0] c_lv, c_cnt;

  bcd_counter_ndigit #(.DIGITS(4), .SATURATE(0), .RESET_VAL(16'h0000)) u_a (
    .clk(clk), .grst(a_grst), .enable(a_en), .up(a_up), .load(a_load),
    .load_val(a_lv), .count(a_cnt), .cout(a_cout), .load_err(a_err));

  bcd_counter_ndigit #(.DIGITS(4), .SATURATE(1), .RESET_VAL(16'h0000)) u_s (
    .clk(clk), .grst(s_grst), .enable(s_en), .up(s_up), .load(s_load),
    .load_val(s_lv), .count(s_cnt), .cout(s_cout), .load_err(s_err));

  bcd_counter_ndigit #(.DIGITS(1), .SATURATE(0), .RESET_VAL(4'h0)) u_b (
    .clk(clk), .grst(b_grst), .enable(b_en), .up(b_up), .load(b_load),
    .load_val(b_lv), .count(b_cnt), .cout(b_cout), .load_err(b_err));

  bcd_counter_ndigit #(.DIGITS(8), .SATURATE(0), .RESET_VAL(32'h0000_0000)) u_c (
    .clk(clk), .grst(c_grst), .enable(c_en), .up(c_up), .load(c_load),
    .load_val(c_lv), .count(c_cnt), .cout(c_cout), .load_err(c_err));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] b_exp;

  initial begin
    a_grst = 0; a_en = 1; a_up = 1; a_load = 0; a_lv = '0;
    s_grst = 0; s_en = 0; s_up = 1; s_load = 0; s_lv = '0;
    b_grst = 0; b_en = 0; b_up = 1; b_load = 0; b_lv = '0;
    c_grst = 0; c_en = 0; c_up = 1; c_load = 0; c_lv = '0;
    #1;

    // Reset held 3 cycles with enable high
    repeat (3) tick();
    check("rst_count", a_cnt, 32'h0000);
    check("rst_cout", a_cout, 0);
    check("rst_err", a_err, 0);
    check("rst_s_count", s_cnt, 32'h0000);
    check("rst_b_count", b_cnt, 32'h0);
    check("rst_c_count", c_cnt, 32'h0);
    a_grst = 1; s_grst = 1; b_grst = 1; c_grst = 1;
    tick();
    check("first_inc", a_cnt, 32'h0001);

    // Up-count with cascading
    a_load = 1; a_lv = 16'h0998; tick();
    check("load_0998", a_cnt, 32'h0998);
    a_load = 0;
    tick(); check("casc_0999", a_cnt, 32'h0999); check("casc_cout0", a_cout, 0);
    tick(); check("casc_1000", a_cnt, 32'h1000); check("casc_cout1", a_cout, 0);
    tick(); check("casc_1001", a_cnt, 32'h1001); check("casc_cout2", a_cout, 0);

    // Wrap at TOP
    a_load = 1; a_lv = 16'h9998; tick();
    a_load = 0;
    tick(); check("wrap_9999", a_cnt, 32'h9999); check("wrap_cout_a", a_cout, 0);
    tick(); check("wrap_0000", a_cnt, 32'h0000); check("wrap_cout_b", a_cout, 1);
    tick(); check("wrap_0001", a_cnt, 32'h0001); check("wrap_cout_c", a_cout, 0);

    // Down through BOT, direction change without a dead cycle
    a_up = 0;
    tick(); check("down_0000", a_cnt, 32'h0000); check("down_cout_a", a_cout, 0);
    tick(); check("down_9999", a_cnt, 32'h9999); check("down_cout_b", a_cout, 1);
    tick(); check("down_9998", a_cnt, 32'h9998); check("down_cout_c", a_cout, 0);

    // Hold
    a_en = 0;
    tick(); check("hold_cnt", a_cnt, 32'h9998); check("hold_cout", a_cout, 0);

    // Load with a non-BCD nibble
    a_load = 1; a_lv = 16'h12A4; tick();
    check("clamp_cnt", a_cnt, 32'h1294); check("clamp_err", a_err, 1);
    a_load = 0;
    tick(); check("clamp_err_clr", a_err, 0); check("clamp_hold", a_cnt, 32'h1294);

    // Load beats enable
    a_load = 1; a_en = 1; a_up = 1; a_lv = 16'h0500; tick();
    check("load_prio", a_cnt, 32'h0500); check("load_prio_err", a_err, 0);
    check("load_prio_cout", a_cout, 0);

    // Reset beats load
    a_grst = 0; a_lv = 16'h4321; tick();
    check("rst_prio", a_cnt, 32'h0000);
    a_grst = 1; a_load = 0; a_en = 0;

    // Saturate configuration
    s_load = 1; s_lv = 16'h9999; tick();
    s_load = 0; s_en = 1; s_up = 1;
    tick(); check("sat_hold_a", s_cnt, 32'h9999); check("sat_cout_a", s_cout, 1);
    tick(); check("sat_hold_b", s_cnt, 32'h9999); check("sat_cout_b", s_cout, 1);
    s_up = 0;
    tick(); check("sat_down", s_cnt, 32'h9998); check("sat_cout_c", s_cout, 0);
    s_load = 1; s_lv = 16'h0000; tick();
    s_load = 0;
    tick(); check("sat_bot", s_cnt, 32'h0000); check("sat_bot_cout", s_cout, 1);
    s_en = 0;

    // 1-digit full up cycle, wrap at 9
    b_en = 1; b_up = 1; b_exp = 4'd0;
    for (int i = 0; i < 12; i++) begin
      b_exp = (b_exp == 4'd9) ? 4'd0 : b_exp + 4'd1;
      tick();
      check("d1_cnt", b_cnt, b_exp);
      check("d1_cout", b_cout, (b_exp == 4'd0));
    end
    b_load = 1; b_lv = 4'hC; tick();
    check("d1_clamp", b_cnt, 32'h9); check("d1_err", b_err, 1);
    b_load = 1; b_lv = 4'h0; tick();
    b_load = 0; b_up = 0;
    tick(); check("d1_down_wrap", b_cnt, 32'h9); check("d1_down_cout", b_cout, 1);
    b_en = 0;

    // 8-digit wrap at 99999999
    c_load = 1; c_lv = 32'h9999_9998; tick();
    c_load = 0; c_en = 1; c_up = 1;
    tick(); check("d8_top", c_cnt, 32'h9999_9999); check("d8_cout_a", c_cout, 0);
    tick(); check("d8_wrap", c_cnt, 32'h0000_0000); check("d8_cout_b", c_cout, 1);
    tick(); check("d8_one", c_cnt, 32'h0000_0001); check("d8_cout_c", c_cout, 0);
    c_up = 0;
    tick(); check("d8_zero", c_cnt, 32'h0000_0000);
    tick(); check("d8_dwrap", c_cnt, 32'h9999_9999); check("d8_cout_d", c_cout, 1);
    c_en = 0; c_load = 1; c_lv = 32'hF000_0000; tick();
    check("d8_clamp", c_cnt, 32'h9000_0000); check("d8_err", c_err, 1);
    c_load = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
